// File: rtl/mc_phase_sequencer_if.sv
// Decoder <-> phase sequencer bundle: per-instruction length and hold/abort
// requests in one direction, phase strobes and status in the other.
interface mc_phase_sequencer_if #(
  parameter int NPHASE = 5,
  parameter int CW     = 3,
  parameter int IW     = 32
);
  logic [CW-1:0]     ilen;
  logic              stall;
  logic              trap;
  logic [NPHASE-1:0] phase;
  logic [CW-1:0]     phase_idx;
  logic              cpu_rst;
  logic              instr_done;
  logic              trap_ack;
  logic [IW-1:0]     instr_cnt;

  modport master (
    output ilen, stall, trap,
    input  phase, phase_idx, cpu_rst, instr_done, trap_ack, instr_cnt
  );

  modport slave (
    input  ilen, stall, trap,
    output phase, phase_idx, cpu_rst, instr_done, trap_ack, instr_cnt
  );
endinterface

// File: rtl/mc_phase_sequencer.sv
// Variable-length one-hot phase sequencer for the multicycle CPU, with stall
// hold, trap-forced restart at phase 0 and a retired-instruction counter.
module mc_phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int CW     = 3,
  parameter int IW     = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  mc_phase_sequencer_if.slave  bus
);
  // Lengths need one extra bit: NPHASE itself may equal 2^CW.
  localparam int             LW  = CW + 1;
  localparam logic [LW-1:0]  NPH = LW'(NPHASE);

  typedef enum logic [1:0] {RST, IDLE, RUN} state_t;

  state_t        state, stateD;
  logic [CW-1:0] idx, idxD;
  logic [LW-1:0] lenQ, lenD, lenEff, ilenExt;
  logic [IW-1:0] cnt, cntD;

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= RST;
      idx   <= '0;
      lenQ  <= NPH;
      cnt   <= '0;
    end else begin
      state <= stateD;
      idx   <= idxD;
      lenQ  <= lenD;
      cnt   <= cntD;
    end
  end

  always_comb begin
    ilenExt = {1'b0, bus.ilen};
    if (idx == '0)
      lenEff = (ilenExt == '0 || ilenExt > NPH) ? NPH : ilenExt;
    else
      lenEff = lenQ;
  end

  always_comb begin
    stateD         = state;
    idxD           = idx;
    lenD           = lenQ;
    cntD           = cnt;
    bus.phase      = '0;
    bus.phase_idx  = '0;
    bus.cpu_rst    = 1'b1;
    bus.instr_done = 1'b0;
    bus.trap_ack   = 1'b0;
    case (state)
      RST:  stateD = IDLE;
      IDLE: begin
        stateD = RUN;
        idxD   = '0;
      end
      RUN: begin
        bus.phase     = NPHASE'(1) << idx;
        bus.phase_idx = idx;
        bus.cpu_rst   = 1'b0;
        if (idx == '0) lenD = lenEff;
        if (bus.trap) begin
          idxD         = '0;
          bus.trap_ack = 1'b1;
        end else if (bus.stall) begin
          idxD = idx;
          lenD = lenQ;
        end else if ({1'b0, idx} == lenEff - LW'(1)) begin
          idxD           = '0;
          bus.instr_done = 1'b1;
          cntD           = cnt + IW'(1);
        end else begin
          idxD = idx + CW'(1);
        end
      end
      default: stateD = RST;
    endcase
  end

  assign bus.instr_cnt = cnt;
endmodule

// File: tb/tb_mc_phase_sequencer.sv
// Directed bench for mc_phase_sequencer: a default-width instance for the
// sequencing cases and a 4-bit-counter instance for counter wrap.
module tb_mc_phase_sequencer;
  logic clk = 1'b0;
  logic clr, clr2;
  int   compared = 0;
  int   failed   = 0;
  int   expCnt   = 0;

  always #5 clk = ~clk;

  mc_phase_sequencer_if #(.NPHASE(5), .CW(3), .IW(32)) bus ();
  mc_phase_sequencer_if #(.NPHASE(5), .CW(3), .IW(4))  bus2 ();

  mc_phase_sequencer #(.NPHASE(5), .CW(3), .IW(32)) dut (
    .clk(clk), .clr(clr), .bus(bus)
  );
  mc_phase_sequencer #(.NPHASE(5), .CW(3), .IW(4)) dut2 (
    .clk(clk), .clr(clr2), .bus(bus2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from P0; ilen switches to ilenMid during P1.
  task automatic runInstr(input int ilen0, input int ilenMid, input int expLen);
    bus.ilen = 3'(ilen0);
    for (int k = 0; k < expLen; k++) begin
      if (k == 1) bus.ilen = 3'(ilenMid);
      #1;
      chk($sformatf("len%0d_phase_k%0d", ilen0, k), 32'(bus.phase), 32'(1) << k);
      chk($sformatf("len%0d_idx_k%0d", ilen0, k), 32'(bus.phase_idx), 32'(k));
      chk($sformatf("len%0d_done_k%0d", ilen0, k), 32'(bus.instr_done), 32'(k == expLen - 1));
      cyc();
    end
    expCnt++;
    #1;
    chk($sformatf("len%0d_cnt", ilen0), bus.instr_cnt, 32'(expCnt));
  endtask

  initial begin
    clr = 1'b1; clr2 = 1'b1;
    bus.ilen = 3'd5; bus.stall = 1'b0; bus.trap = 1'b0;
    bus2.ilen = 3'd1; bus2.stall = 1'b0; bus2.trap = 1'b0;

    // reset held 3 edges; stall/trap must be ignored here
    bus.stall = 1'b1; bus.trap = 1'b1;
    repeat (3) cyc();
    chk("rst_phase", 32'(bus.phase), 32'h0);
    chk("rst_cpu_rst", 32'(bus.cpu_rst), 32'h1);
    chk("rst_cnt", bus.instr_cnt, 32'h0);
    chk("rst_trap_ack", 32'(bus.trap_ack), 32'h0);
    clr = 1'b0;
    cyc();
    chk("idle_phase", 32'(bus.phase), 32'h0);
    chk("idle_cpu_rst", 32'(bus.cpu_rst), 32'h1);
    chk("idle_trap_ack", 32'(bus.trap_ack), 32'h0);
    bus.stall = 1'b0; bus.trap = 1'b0;
    cyc();
    chk("run_cpu_rst", 32'(bus.cpu_rst), 32'h0);

    // 10 RUN cycles of 5-phase instructions
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("seq_phase_%0d", i), 32'(bus.phase), 32'(1) << (i % 5));
      chk($sformatf("seq_done_%0d", i), 32'(bus.instr_done), 32'((i % 5) == 4));
      cyc();
    end
    expCnt = 2;
    chk("seq_cnt", bus.instr_cnt, 32'(expCnt));

    // variable length, clamps, and ilen change mid-instruction
    runInstr(3, 3, 3);
    runInstr(0, 0, 5);
    runInstr(7, 7, 5);
    runInstr(3, 2, 3);

    // stall in P2 for 4 edges
    bus.ilen = 3'd5;
    cyc(); cyc();
    bus.stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk($sformatf("stall_phase_%0d", s), 32'(bus.phase), 32'h04);
      chk($sformatf("stall_done_%0d", s), 32'(bus.instr_done), 32'h0);
      cyc();
    end
    bus.stall = 1'b0;
    #1;
    chk("stall_release_phase", 32'(bus.phase), 32'h04);
    cyc();
    chk("stall_p3", 32'(bus.phase), 32'h08);
    chk("stall_cnt_p3", bus.instr_cnt, 32'(expCnt));
    cyc();
    chk("stall_p4_done", 32'(bus.instr_done), 32'h1);
    cyc();
    expCnt++;
    chk("stall_cnt_after", bus.instr_cnt, 32'(expCnt));

    // trap in P3
    cyc(); cyc(); cyc();
    chk("trap_pre_p3", 32'(bus.phase), 32'h08);
    bus.trap = 1'b1;
    #1;
    chk("trap_ack_p3", 32'(bus.trap_ack), 32'h1);
    chk("trap_done_p3", 32'(bus.instr_done), 32'h0);
    cyc();
    bus.trap = 1'b0;
    #1;
    chk("trap_restart_p0", 32'(bus.phase), 32'h01);
    chk("trap_ack_clear", 32'(bus.trap_ack), 32'h0);
    chk("trap_cnt", bus.instr_cnt, 32'(expCnt));

    // trap with stall in P1
    cyc();
    bus.trap = 1'b1; bus.stall = 1'b1;
    #1;
    chk("trapstall_p1", 32'(bus.phase), 32'h02);
    chk("trapstall_ack", 32'(bus.trap_ack), 32'h1);
    cyc();
    bus.stall = 1'b0;
    #1;
    chk("trapstall_p0", 32'(bus.phase), 32'h01);

    // trap held: stays in P0, ack every cycle
    for (int t = 0; t < 3; t++) begin
      cyc();
      chk($sformatf("traphold_phase_%0d", t), 32'(bus.phase), 32'h01);
      chk($sformatf("traphold_ack_%0d", t), 32'(bus.trap_ack), 32'h1);
    end
    bus.trap = 1'b0;
    chk("traphold_cnt", bus.instr_cnt, 32'(expCnt));

    // clr mid-instruction in P2
    cyc(); cyc();
    chk("midrst_pre_p2", 32'(bus.phase), 32'h04);
    clr = 1'b1;
    cyc();
    chk("midrst_phase", 32'(bus.phase), 32'h0);
    chk("midrst_cpu_rst", 32'(bus.cpu_rst), 32'h1);
    chk("midrst_cnt", bus.instr_cnt, 32'h0);
    clr = 1'b0;
    cyc();
    chk("midrst_idle_cpu_rst", 32'(bus.cpu_rst), 32'h1);
    cyc();
    chk("midrst_restart_p0", 32'(bus.phase), 32'h01);
    chk("midrst_restart_cnt", bus.instr_cnt, 32'h0);

    // 4-bit counter wrap with single-phase instructions
    clr2 = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("wrap_phase_%0d", i), 32'(bus2.phase), 32'h01);
      chk($sformatf("wrap_done_%0d", i), 32'(bus2.instr_done), 32'h1);
      chk($sformatf("wrap_cnt_%0d", i), 32'(bus2.instr_cnt), 32'(i));
      cyc();
    end
    chk("wrap_cnt_zero", 32'(bus2.instr_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
